// File: rtl/gate_ctrl_pkg.sv
// gate_ctrl_pkg: shared FSM encoding and saturation helper for the gate controller
package gate_ctrl_pkg;

   typedef enum logic [1:0] {INIT, JUDGE, GRANT, WAIT} state_t;

   localparam int SAT_W = 32;

   function automatic logic [SAT_W-1:0] sat_min(
      input logic [SAT_W-1:0] a,
      input logic [SAT_W-1:0] b
   );
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/tb_bucket.sv
// tb_bucket: one per-queue token bucket with shared replenish strobe
module tb_bucket
   import gate_ctrl_pkg::*;
#(
   parameter int LEN_W      = 11,
   parameter int TOKEN_W    = 16,
   parameter int SHAPE_MODE = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               repl,
   input  logic               rden,
   input  logic [LEN_W-1:0]   len,
   input  logic [TOKEN_W-1:0] rate,
   input  logic [TOKEN_W-1:0] size,
   output logic [TOKEN_W-1:0] tokens,
   output logic               discard,
   output logic               tok_ok
);

   logic [TOKEN_W:0] len_x;
   logic [TOKEN_W:0] cons;
   logic [TOKEN_W:0] sum;

   assign len_x  = (TOKEN_W+1)'(len);
   assign tok_ok = {1'b0, tokens} >= len_x;
   assign cons   = (rden && tok_ok) ? len_x : '0;
   // cons never exceeds tokens, so the sum cannot underflow
   assign sum    = {1'b0, tokens} + (repl ? {1'b0, rate} : '0) - cons;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tokens  <= '0;
         discard <= 1'b0;
      end else begin
         tokens  <= TOKEN_W'(sat_min(SAT_W'(sum), SAT_W'(size)));
         discard <= (SHAPE_MODE == 0) && rden && !tok_ok;
      end

endmodule

// File: rtl/gate_ctrl_nq.sv
// gate_ctrl_nq: per-slot eligibility of NUM_Q egress queues for the transmit scheduler
module gate_ctrl_nq
   import gate_ctrl_pkg::*;
#(
   parameter int               NUM_Q       = 8,
   parameter int               LEN_W       = 11,
   parameter int               TOKEN_W     = 16,
   parameter int               TB_PERIOD   = 1000,
   parameter int               USEDW_W     = 8,
   parameter int               USEDW_TH    = 20,
   parameter logic [NUM_Q-1:0] SHAPED_MASK = 8'h04,
   parameter int               SHAPE_MODE  = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_Q-1:0]           in_gate_mask,
   input  logic [NUM_Q-1:0]           in_fifo_empty,
   input  logic [NUM_Q*LEN_W-1:0]     in_head_len,
   input  logic [NUM_Q*TOKEN_W-1:0]   in_rate,
   input  logic [NUM_Q*TOKEN_W-1:0]   in_tb_size,
   input  logic [USEDW_W-1:0]         in_pktout_usedw,
   input  logic                       in_pkt_done,
   input  logic [NUM_Q-1:0]           in_q_rden,
   output logic [NUM_Q-1:0]           out_schedule_valid,
   output logic [NUM_Q-1:0]           out_discard,
   output logic [NUM_Q*TOKEN_W-1:0]   out_tokens
);

   localparam int TMR_W = (TB_PERIOD > 1) ? $clog2(TB_PERIOD) : 1;

   logic [TMR_W-1:0] timer;
   logic             repl;
   logic             usedw_ok;
   logic [NUM_Q-1:0] tok_ok;
   logic [NUM_Q-1:0] elig;
   logic             unused;
   state_t           state;

   // inputs of unshaped queues are legitimately ignored
   assign unused   = ^{in_head_len, in_rate, in_tb_size};
   assign repl     = timer == TMR_W'(TB_PERIOD - 1);
   assign usedw_ok = in_pktout_usedw <= USEDW_W'(USEDW_TH);
   assign elig     = in_gate_mask & ~in_fifo_empty & {NUM_Q{usedw_ok}} & tok_ok;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) timer <= '0;
      else        timer <= repl ? '0 : timer + 1'b1;

   for (genvar i = 0; i < NUM_Q; i++) begin : g_q
      if (SHAPED_MASK[i]) begin : g_sh
         logic ok_raw;
         tb_bucket #(
            .LEN_W     (LEN_W),
            .TOKEN_W   (TOKEN_W),
            .SHAPE_MODE(SHAPE_MODE)
         ) u_bucket (
            .clk    (clk),
            .rst_n  (rst_n),
            .repl   (repl),
            .rden   (in_q_rden[i]),
            .len    (in_head_len[i*LEN_W +: LEN_W]),
            .rate   (in_rate[i*TOKEN_W +: TOKEN_W]),
            .size   (in_tb_size[i*TOKEN_W +: TOKEN_W]),
            .tokens (out_tokens[i*TOKEN_W +: TOKEN_W]),
            .discard(out_discard[i]),
            .tok_ok (ok_raw)
         );
         assign tok_ok[i] = (SHAPE_MODE == 0) || ok_raw;
      end else begin : g_un
         assign out_tokens[i*TOKEN_W +: TOKEN_W] = '0;
         assign out_discard[i]                   = 1'b0;
         assign tok_ok[i]                        = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state              <= INIT;
         out_schedule_valid <= '0;
      end else begin
         case (state)
            INIT:  state <= JUDGE;
            JUDGE: if (|elig) begin
               out_schedule_valid <= elig;
               state              <= GRANT;
            end
            GRANT: begin
               out_schedule_valid <= '0;
               state              <= WAIT;
            end
            WAIT:    if (in_pkt_done) state <= JUDGE;
            default: state <= INIT;
         endcase
      end

endmodule

// File: tb/tb_gate_ctrl_nq.sv
// tb_gate_ctrl_nq: policer and shaper instances driven together against a behavioural model
module tb_gate_ctrl_nq;

   localparam int NQ = 8, LW = 11, TW = 16, PER = 1000, UW = 8, TH = 20;
   localparam logic [NQ-1:0] SH = 8'h04;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NQ-1:0] gate, empty, rden;
   logic [NQ*LW-1:0] hlen;
   logic [NQ*TW-1:0] rate, size;
   logic [UW-1:0] usedw;
   logic done;
   logic [NQ-1:0] v0, v1, d0, d1;
   logic [NQ*TW-1:0] t0, t1;

   int n_tests = 0, n_fail = 0;

   int m_rt[NQ];
   int m_timer;
   int m_st[2];
   logic [NQ-1:0] m_valid[2];
   logic [NQ-1:0] m_disc;

   always #5 clk = ~clk;

   gate_ctrl_nq #(.SHAPE_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_gate_mask(gate), .in_fifo_empty(empty),
      .in_head_len(hlen), .in_rate(rate), .in_tb_size(size), .in_pktout_usedw(usedw),
      .in_pkt_done(done), .in_q_rden(rden), .out_schedule_valid(v0),
      .out_discard(d0), .out_tokens(t0));

   gate_ctrl_nq #(.SHAPE_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_gate_mask(gate), .in_fifo_empty(empty),
      .in_head_len(hlen), .in_rate(rate), .in_tb_size(size), .in_pktout_usedw(usedw),
      .in_pkt_done(done), .in_q_rden(rden), .out_schedule_valid(v1),
      .out_discard(d1), .out_tokens(t1));

   function automatic int len_of(int q);
      return int'(hlen[q*LW +: LW]);
   endfunction

   function automatic int tok0(int q);
      return int'(t0[q*TW +: TW]);
   endfunction

   function automatic int tok1(int q);
      return int'(t1[q*TW +: TW]);
   endfunction

   task automatic idle_inputs();
      gate = '0; empty = '1; rden = '0; hlen = '0; rate = '0; size = '0; usedw = '0; done = 1'b0;
   endtask

   task automatic model_reset();
      foreach (m_rt[q]) m_rt[q] = 0;
      m_timer = 0;
      m_st[0] = 0; m_st[1] = 0;
      m_valid[0] = '0; m_valid[1] = '0;
      m_disc = '0;
   endtask

   // Advance the model by one clock using the current inputs, then clock the DUTs.
   // Phases: 0 start-up, 1 judging, 2 granted, 3 awaiting packet completion.
   task automatic step();
      int nrt[NQ];
      logic [NQ-1:0] el[2];
      logic refill;
      refill = (m_timer == PER - 1);
      for (int q = 0; q < NQ; q++) begin
         nrt[q] = 0;
         m_disc[q] = 1'b0;
         if (SH[q]) begin
            int spend;
            spend = (rden[q] && m_rt[q] >= len_of(q)) ? len_of(q) : 0;
            m_disc[q] = rden[q] && m_rt[q] < len_of(q);
            nrt[q] = m_rt[q] + (refill ? int'(rate[q*TW +: TW]) : 0) - spend;
            if (nrt[q] > int'(size[q*TW +: TW])) nrt[q] = int'(size[q*TW +: TW]);
         end
      end
      for (int m = 0; m < 2; m++) begin
         for (int q = 0; q < NQ; q++)
            el[m][q] = gate[q] && !empty[q] && (int'(usedw) <= TH) &&
                       (!SH[q] || m == 0 || m_rt[q] >= len_of(q));
         case (m_st[m])
            0: m_st[m] = 1;
            1: if (el[m] != '0) begin m_valid[m] = el[m]; m_st[m] = 2; end
            2: begin m_valid[m] = '0; m_st[m] = 3; end
            default: if (done) m_st[m] = 1;
         endcase
      end
      m_rt = nrt;
      m_timer = refill ? 0 : m_timer + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      n_tests++; if (v0 !== '0) begin n_fail++; $display("FAIL reset_valid0: got %h expected 00", v0); end
      n_tests++; if (v1 !== '0) begin n_fail++; $display("FAIL reset_valid1: got %h expected 00", v1); end
      n_tests++; if (d0 !== '0) begin n_fail++; $display("FAIL reset_discard0: got %h expected 00", d0); end
      n_tests++; if (d1 !== '0) begin n_fail++; $display("FAIL reset_discard1: got %h expected 00", d1); end
      n_tests++; if (t0 !== '0) begin n_fail++; $display("FAIL reset_tokens0: got %h expected 0", t0); end
      n_tests++; if (t1 !== '0) begin n_fail++; $display("FAIL reset_tokens1: got %h expected 0", t1); end
      rst_n = 1'b1;
   endtask

   task automatic test_first_grant();
      logic [NQ-1:0] seen;
      gate = 8'h01; empty = 8'hFE; usedw = 8'd5;
      step();
      n_tests++; if (v0 !== 8'h00) begin n_fail++; $display("FAIL grant_cycle1: got %h expected 00", v0); end
      step();
      n_tests++; if (v0 !== 8'h01) begin n_fail++; $display("FAIL grant_cycle2_q0: got %h expected 01", v0); end
      n_tests++; if (v1 !== 8'h01) begin n_fail++; $display("FAIL grant_cycle2_q0_shaper: got %h expected 01", v1); end
      step();
      n_tests++; if (v0 !== 8'h00) begin n_fail++; $display("FAIL grant_one_cycle: got %h expected 00", v0); end
      seen = '0;
      repeat (6) begin step(); seen |= v0 | v1; end
      n_tests++; if (seen !== 8'h00) begin n_fail++; $display("FAIL grant_wait_hold: got %h expected 00", seen); end
      done = 1'b1; step(); done = 1'b0;
      n_tests++; if (v0 !== 8'h00) begin n_fail++; $display("FAIL done_cycle1: got %h expected 00", v0); end
      step();
      n_tests++; if (v0 !== 8'h01) begin n_fail++; $display("FAIL done_cycle2: got %h expected 01", v0); end
      step();
   endtask

   task automatic test_usedw();
      logic [NQ-1:0] seen;
      gate = 8'hFF; empty = 8'h00; hlen = '0; usedw = 8'd21;
      done = 1'b1; step(); done = 1'b0;
      seen = '0;
      repeat (4) begin step(); seen |= v0 | v1; end
      n_tests++; if (seen !== 8'h00) begin n_fail++; $display("FAIL usedw21_blocked: got %h expected 00", seen); end
      usedw = 8'd20;
      step();
      n_tests++; if (v0 !== 8'hFF) begin n_fail++; $display("FAIL usedw20_valid0: got %h expected ff", v0); end
      n_tests++; if (v1 !== 8'hFF) begin n_fail++; $display("FAIL usedw20_valid1: got %h expected ff", v1); end
      step();
      n_tests++; if (v0 !== 8'h00) begin n_fail++; $display("FAIL usedw20_pulse: got %h expected 00", v0); end
   endtask

   task automatic test_policer();
      apply_reset();
      rate[2*TW +: TW] = 16'd100; size[2*TW +: TW] = 16'd300; hlen[2*LW +: LW] = 11'd150;
      repeat (3 * PER) step();
      n_tests++; if (tok0(2) !== 300) begin n_fail++; $display("FAIL pol_saturate: got %0d expected 300", tok0(2)); end
      n_tests++; if (tok0(0) !== 0) begin n_fail++; $display("FAIL pol_unshaped_q0: got %0d expected 0", tok0(0)); end
      rden = 8'h04; step(); rden = '0;
      n_tests++; if (tok0(2) !== 150) begin n_fail++; $display("FAIL pol_rden1: got %0d expected 150", tok0(2)); end
      rden = 8'h04; step(); rden = '0;
      n_tests++; if (tok0(2) !== 0) begin n_fail++; $display("FAIL pol_rden2: got %0d expected 0", tok0(2)); end
      n_tests++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL pol_no_discard: got %h expected 00", d0); end
      rden = 8'h04; step(); rden = '0;
      n_tests++; if (d0 !== 8'h04) begin n_fail++; $display("FAIL pol_discard: got %h expected 04", d0); end
      n_tests++; if (tok0(2) !== 0) begin n_fail++; $display("FAIL pol_discard_rt: got %0d expected 0", tok0(2)); end
      n_tests++; if (d1 !== 8'h00) begin n_fail++; $display("FAIL shaper_discard_tied: got %h expected 00", d1); end
      step();
      n_tests++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL pol_discard_pulse: got %h expected 00", d0); end
   endtask

   task automatic test_shaper();
      logic [NQ-1:0] seen;
      apply_reset();
      rate[2*TW +: TW] = 16'd100; size[2*TW +: TW] = 16'd300; hlen[2*LW +: LW] = 11'd150;
      gate = 8'h04; empty = 8'hFB; usedw = 8'd5;
      seen = '0;
      for (int k = 0; k < PER && m_timer != PER - 1; k++) begin step(); seen |= v1; end
      step(); seen |= v1;
      n_tests++; if (tok1(2) !== 100) begin n_fail++; $display("FAIL shp_rt100: got %0d expected 100", tok1(2)); end
      for (int k = 0; k < PER && m_timer != PER - 1; k++) begin step(); seen |= v1; end
      n_tests++; if (seen !== 8'h00) begin n_fail++; $display("FAIL shp_excluded: got %h expected 00", seen); end
      step();
      n_tests++; if (tok1(2) !== 200) begin n_fail++; $display("FAIL shp_rt200: got %0d expected 200", tok1(2)); end
      step();
      n_tests++; if (v1 !== 8'h04) begin n_fail++; $display("FAIL shp_eligible: got %h expected 04", v1); end
   endtask

   task automatic test_repl_rden();
      apply_reset();
      rate[2*TW +: TW] = 16'd250; size[2*TW +: TW] = 16'd300; hlen[2*LW +: LW] = 11'd200;
      for (int k = 0; k < PER && m_timer != PER - 1; k++) step();
      step();
      n_tests++; if (tok0(2) !== 250) begin n_fail++; $display("FAIL rr_rt250: got %0d expected 250", tok0(2)); end
      rate[2*TW +: TW] = 16'd100;
      for (int k = 0; k < PER && m_timer != PER - 1; k++) step();
      rden = 8'h04; step(); rden = '0;
      n_tests++; if (tok0(2) !== 150) begin n_fail++; $display("FAIL rr_same_cycle: got %0d expected 150", tok0(2)); end
      size[2*TW +: TW] = 16'd50;
      step();
      n_tests++; if (tok0(2) !== 50) begin n_fail++; $display("FAIL rr_clamp: got %0d expected 50", tok0(2)); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 4000; c++) begin
         gate = NQ'($urandom);
         empty = NQ'($urandom & $urandom);
         usedw = UW'($urandom_range(14, 26));
         for (int q = 0; q < NQ; q++) begin
            hlen[q*LW +: LW] = LW'($urandom_range(0, 400));
            rate[q*TW +: TW] = TW'($urandom_range(0, 500));
            size[q*TW +: TW] = TW'($urandom_range(100, 700));
         end
         rden = ($urandom_range(0, 2) == 0) ? NQ'($urandom) : '0;
         done = ($urandom_range(0, 3) == 0);
         step();
         n_tests++; if (v0 !== m_valid[0]) begin n_fail++; $display("FAIL rnd_valid0 c=%0d: got %h expected %h", c, v0, m_valid[0]); end
         n_tests++; if (v1 !== m_valid[1]) begin n_fail++; $display("FAIL rnd_valid1 c=%0d: got %h expected %h", c, v1, m_valid[1]); end
         n_tests++; if (d0 !== m_disc) begin n_fail++; $display("FAIL rnd_discard0 c=%0d: got %h expected %h", c, d0, m_disc); end
         n_tests++; if (d1 !== '0) begin n_fail++; $display("FAIL rnd_discard1 c=%0d: got %h expected 00", c, d1); end
         for (int q = 0; q < NQ; q++) begin
            n_tests++; if (tok0(q) !== m_rt[q]) begin n_fail++; $display("FAIL rnd_tokens0 c=%0d q=%0d: got %0d expected %0d", c, q, tok0(q), m_rt[q]); end
            n_tests++; if (tok1(q) !== m_rt[q]) begin n_fail++; $display("FAIL rnd_tokens1 c=%0d q=%0d: got %0d expected %0d", c, q, tok1(q), m_rt[q]); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      gate = 8'h01; empty = 8'hFE; usedw = 8'd5;
      rate[2*TW +: TW] = 16'd200; size[2*TW +: TW] = 16'd300; hlen[2*LW +: LW] = 11'd50;
      for (int k = 0; k < 2 * PER + 4 && !(m_st[0] == 3 && m_rt[2] != 0); k++) step();
      n_tests++; if (tok0(2) === 0) begin n_fail++; $display("FAIL mid_precond_tokens: got %0d expected nonzero", tok0(2)); end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++; if (v0 !== '0) begin n_fail++; $display("FAIL mid_valid: got %h expected 00", v0); end
      n_tests++; if (d0 !== '0) begin n_fail++; $display("FAIL mid_discard: got %h expected 00", d0); end
      n_tests++; if (t0 !== '0) begin n_fail++; $display("FAIL mid_tokens0: got %h expected 0", t0); end
      n_tests++; if (t1 !== '0) begin n_fail++; $display("FAIL mid_tokens1: got %h expected 0", t1); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      n_tests++; if (v0 !== 8'h00) begin n_fail++; $display("FAIL mid_restart_c1: got %h expected 00", v0); end
      step();
      n_tests++; if (v0 !== 8'h01) begin n_fail++; $display("FAIL mid_restart_c2: got %h expected 01", v0); end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_usedw();
      test_policer();
      test_shaper();
      test_repl_rden();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
